// File: rtl/opb_reg_bank_pkg.sv
// Shared types and constants for the OPB snapshot register bank.
package opb_reg_bank_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ACK    = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam int unsigned CTRL_OFF      = 0;
  localparam int          CTRL_ARM      = 0;
  localparam int          CTRL_CLR_DONE = 1;
  localparam int          CTRL_CNT_LSB  = 8;
  localparam int          CTRL_CNT_MSB  = 15;

endpackage

// File: rtl/opb_reg_bank_ctrl_snapshot.sv
// Arm/done/count flags and the coherent shadow copy of the user words.
module reg_bank_snapshot #(
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  clr_done,
  input  logic                  user_valid,
  input  logic [NUM_REGS*32-1:0] user_data_in,
  output logic                  armed,
  output logic                  done,
  output logic [7:0]            cnt,
  output logic [NUM_REGS*32-1:0] shadow
);

  logic                   armed_q;
  logic                   done_q;
  logic [7:0]             cnt_q;
  logic [NUM_REGS*32-1:0] shadow_q;

  // Bus writes are applied after the capture so an arm landing with
  // a capture re-arms for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 8'd0;
      shadow_q <= '0;
    end else begin
      if (armed_q && user_valid) begin
        shadow_q <= user_data_in;
        done_q   <= 1'b1;
        armed_q  <= 1'b0;
        cnt_q    <= cnt_q + 8'd1;
      end
      if (arm) begin
        armed_q <= 1'b1;
        done_q  <= 1'b0;
      end else if (clr_done) begin
        done_q <= 1'b0;
      end
    end
  end

  assign armed  = armed_q;
  assign done   = done_q;
  assign cnt    = cnt_q;
  assign shadow = shadow_q;

endmodule

// File: rtl/opb_reg_bank_ctrl.sv
// OPB slave exposing a CTRL word and a bank of snapshot shadow registers.
module opb_reg_bank_ctrl #(
  parameter logic [31:0] C_BASEADDR   = 32'h01004000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010040FF,
  parameter int          NUM_REGS     = 8,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [NUM_REGS*32-1:0]    user_data_in,
  input  logic                      user_valid,
  output logic                      snap_armed,
  output logic                      snap_done
);

  import opb_reg_bank_pkg::*;

  state_t      state_q;
  logic [31:0] off_q;
  logic        rnw_q;
  logic        be3_q;
  logic [1:0]  wbits_q;
  logic        valid_q;
  logic [31:0] rd_q;

  logic        hit;
  logic [31:0] rel;
  logic [31:0] dbus_w;
  logic [31:0] ctrl_word;
  logic [31:0] rd_nxt;
  logic        in_ack;
  logic        wr_ctrl;
  logic        arm;
  logic        clr_done;
  logic        armed;
  logic        done;
  logic [7:0]  cnt;
  logic [NUM_REGS*32-1:0] shadow;
  logic        unused_ok;

  // OPB bit 0 is the MSB, so the numeric value maps straight across.
  assign dbus_w = OPB_DBus;
  assign rel    = OPB_ABus - C_BASEADDR;
  assign hit    = OPB_select
               && (OPB_ABus >= C_BASEADDR)
               && (OPB_ABus <= C_HIGHADDR);

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_ARM]      = armed;
    ctrl_word[CTRL_CLR_DONE] = done;
    ctrl_word[CTRL_CNT_MSB:CTRL_CNT_LSB] = cnt;
  end

  always_comb begin
    rd_nxt = '0;
    if (off_q == CTRL_OFF) rd_nxt = ctrl_word;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (off_q == 32'(i + 1)) rd_nxt = shadow[i*32 +: 32];
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      rnw_q   <= 1'b0;
      be3_q   <= 1'b0;
      wbits_q <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            off_q   <= {2'b00, rel[31:2]};
            rnw_q   <= OPB_RNW;
            be3_q   <= OPB_BE[3];
            wbits_q <= dbus_w[1:0];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          rd_q    <= rd_nxt;
          valid_q <= off_q <= 32'(NUM_REGS);
          state_q <= S_ACK;
        end
        S_ACK:   state_q <= S_GAP;
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ack     = state_q == S_ACK;
  assign Sl_xferAck = in_ack;
  assign Sl_errAck  = in_ack && !valid_q;
  assign Sl_DBus    = (in_ack && rnw_q) ? rd_q : '0;
  assign Sl_toutSup = (state_q == S_DECODE) || in_ack;
  assign Sl_retry   = 1'b0;

  assign wr_ctrl  = in_ack && !rnw_q && valid_q
                 && (off_q == CTRL_OFF) && be3_q;
  assign arm      = wr_ctrl && wbits_q[CTRL_ARM];
  assign clr_done = wr_ctrl && wbits_q[CTRL_CLR_DONE];

  reg_bank_snapshot #(
    .NUM_REGS(NUM_REGS)
  ) u_snap (
    .clk         (OPB_Clk),
    .rst         (OPB_Rst),
    .arm         (arm),
    .clr_done    (clr_done),
    .user_valid  (user_valid),
    .user_data_in(user_data_in),
    .armed       (armed),
    .done        (done),
    .cnt         (cnt),
    .shadow      (shadow)
  );

  assign snap_armed = armed;
  assign snap_done  = done;

  assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2],
                       dbus_w[31:2], rel[1:0]};

endmodule
